// File: rtl/aes_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_txn_sequencer
// Description : Upstream driver for the aes wrapper. Latches one key and one
//               plaintext on start, streams them to the wrapper as LOAD_KEY
//               (optional) and LOAD_TEXT transactions, issues HASH, collects
//               the 16 ciphertext bytes into result and completes the ACK
//               handshake. Any wait longer than TIMEOUT cycles aborts.
// Ports       : clk, rst_n (async, active-high)
//               host side : start, load_key, encdec_in, key_in, text_in,
//                           busy, done, error, result
//               data bus  : aes_data_in/aes_valid_in/aes_ready_in (to wrapper)
//                           aes_data_out/aes_data_valid/aes_data_ready (from)
//               ack       : aes_ack_valid/aes_ack_ready/aes_module_source_id
//               txn bus   : opcode, source_id, dest_id, encdec, addr
// Revision    : 1.0 - initial release
// ============================================================================
module aes_txn_sequencer #(
   parameter int unsigned TIMEOUT   = 1024,
   parameter logic [23:0] KEY_ADDR  = 24'h000000,
   parameter logic [23:0] TEXT_ADDR = 24'h000020,
   parameter logic [23:0] RES_ADDR  = 24'h000030
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         load_key,
   input  logic         encdec_in,
   input  logic [255:0] key_in,
   input  logic [127:0] text_in,
   output logic         busy,
   output logic         done,
   output logic         error,
   output logic [127:0] result,
   output logic [7:0]   aes_data_in,
   output logic         aes_valid_in,
   input  logic         aes_ready_in,
   input  logic [7:0]   aes_data_out,
   input  logic         aes_data_valid,
   output logic         aes_data_ready,
   input  logic         aes_ack_valid,
   output logic         aes_ack_ready,
   input  logic [1:0]   aes_module_source_id,
   output logic [1:0]   opcode,
   output logic [1:0]   source_id,
   output logic [1:0]   dest_id,
   output logic         encdec,
   output logic [23:0]  addr
);

   localparam logic [1:0] C_OP_LOAD_KEY  = 2'b00;
   localparam logic [1:0] C_OP_LOAD_TEXT = 2'b01;
   localparam logic [1:0] C_OP_HASH      = 2'b11;
   localparam logic [1:0] C_ID_MEM       = 2'b00;
   localparam logic [1:0] C_ID_AES       = 2'b10;

   localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_KEY  = 3'd1,
      S_TEXT = 3'd2,
      S_HASH = 3'd3,
      S_RX   = 3'd4,
      S_ACK  = 3'd5,
      S_ERR  = 3'd6
   } state_t;

   state_t         state_q, state_d;
   logic [5:0]     cnt_q, cnt_d;
   logic [TW-1:0]  tmo_q, tmo_d;
   logic [255:0]   key_q, key_d;
   logic [127:0]   text_q, text_d;
   logic           enc_q, enc_d;
   logic [127:0]   result_q, result_d;
   logic [1:0]     opcode_q, opcode_d;
   logic [1:0]     src_q, src_d;
   logic [1:0]     dst_q, dst_d;
   logic [23:0]    addr_q, addr_d;
   logic           encdec_q, encdec_d;
   logic [7:0]     din_q, din_d;
   logic           vin_q, vin_d;
   logic           drdy_q, drdy_d;
   logic           done_q, done_d;
   logic           error_q, error_d;
   logic           beat;
   logic           tmo_hit;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tmo_q    <= '0;
         key_q    <= '0;
         text_q   <= '0;
         enc_q    <= 1'b0;
         result_q <= '0;
         opcode_q <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         addr_q   <= '0;
         encdec_q <= 1'b0;
         din_q    <= '0;
         vin_q    <= 1'b0;
         drdy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         key_q    <= key_d;
         text_q   <= text_d;
         enc_q    <= enc_d;
         result_q <= result_d;
         opcode_q <= opcode_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         addr_q   <= addr_d;
         encdec_q <= encdec_d;
         din_q    <= din_d;
         vin_q    <= vin_d;
         drdy_q   <= drdy_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmo_d    = tmo_q;
      key_d    = key_q;
      text_d   = text_q;
      enc_d    = enc_q;
      result_d = result_q;
      done_d   = 1'b0;
      beat     = vin_q && aes_ready_in;
      tmo_hit  = (tmo_q == C_TMO_LAST);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               key_d   = key_in;
               text_d  = text_in;
               enc_d   = encdec_in;
               cnt_d   = '0;
               tmo_d   = '0;
               state_d = load_key ? S_KEY : S_TEXT;
            end
         end
         S_KEY, S_TEXT: begin
            if (beat) begin
               tmo_d = '0;
               if (state_q == S_KEY && cnt_q == 6'd31) begin
                  cnt_d   = '0;
                  state_d = S_TEXT;
               end else if (state_q == S_TEXT && cnt_q == 6'd15) begin
                  cnt_d   = '0;
                  state_d = S_HASH;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end else if (tmo_hit) begin
               tmo_d   = '0;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_HASH, S_RX: begin
            if (aes_data_valid) begin
               // {~cnt,3'b111} is 127-8*cnt for cnt in 0..15
               result_d[{~cnt_q[3:0], 3'b111} -: 8] = aes_data_out;
               tmo_d = '0;
               if (state_q == S_HASH) begin
                  cnt_d   = cnt_q + 6'd1;
                  state_d = S_RX;
               end else if (cnt_q == 6'd15) begin
                  cnt_d   = '0;
                  state_d = S_ACK;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end else if (tmo_hit) begin
               tmo_d   = '0;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_ACK: begin
            if (aes_ack_valid && aes_module_source_id == C_ID_AES) begin
               done_d  = 1'b1;
               tmo_d   = '0;
               state_d = S_IDLE;
            end else if (tmo_hit) begin
               tmo_d   = '0;
               state_d = S_ERR;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_ERR: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered outputs are decoded from the next state so they line up
      // with the state register in the same cycle.
      opcode_d = C_OP_LOAD_KEY;
      src_d    = C_ID_MEM;
      dst_d    = C_ID_MEM;
      addr_d   = '0;
      encdec_d = 1'b0;
      din_d    = '0;
      vin_d    = 1'b0;
      drdy_d   = 1'b0;
      error_d  = (state_d == S_ERR);

      case (state_d)
         S_KEY: begin
            opcode_d = C_OP_LOAD_KEY;
            dst_d    = C_ID_AES;
            addr_d   = KEY_ADDR;
            encdec_d = enc_d;
            vin_d    = 1'b1;
            // {~cnt,3'b111} is 255-8*cnt for cnt in 0..31
            din_d    = key_d[{~cnt_d[4:0], 3'b111} -: 8];
         end
         S_TEXT: begin
            opcode_d = C_OP_LOAD_TEXT;
            dst_d    = C_ID_AES;
            addr_d   = TEXT_ADDR;
            encdec_d = enc_d;
            vin_d    = 1'b1;
            din_d    = text_d[{~cnt_d[3:0], 3'b111} -: 8];
         end
         S_HASH: begin
            opcode_d = C_OP_HASH;
            dst_d    = C_ID_AES;
            addr_d   = RES_ADDR;
            encdec_d = enc_d;
            drdy_d   = 1'b1;
         end
         S_RX: begin
            addr_d   = RES_ADDR;
            encdec_d = enc_d;
            drdy_d   = 1'b1;
         end
         S_ACK: begin
            addr_d   = RES_ADDR;
            encdec_d = enc_d;
         end
         default: begin
         end
      endcase
   end

   assign busy           = (state_q != S_IDLE);
   assign aes_ack_ready  = (state_q == S_ACK);
   assign done           = done_q;
   assign error          = error_q;
   assign result         = result_q;
   assign aes_data_in    = din_q;
   assign aes_valid_in   = vin_q;
   assign aes_data_ready = drdy_q;
   assign opcode         = opcode_q;
   assign source_id      = src_q;
   assign dest_id        = dst_q;
   assign encdec         = encdec_q;
   assign addr           = addr_q;

endmodule
`default_nettype wire

// File: doc/aes_txn_sequencer.md
# aes_txn_sequencer

Upstream driver for the `aes` wrapper. It accepts one 256-bit key and one 128-bit plaintext from the host side, then issues the wrapper's transaction bus and streams bytes on its DATA bus: LOAD_KEY, LOAD_TEXT, then HASH. It collects the 16 ciphertext bytes into `result` and completes the ACK handshake. It sits between the host/register file and the `aes` block and replaces the memory model that the testbench currently plays.

## Interface
- `TIMEOUT`, default 1024: maximum idle cycles allowed in any wait before aborting.
- `KEY_ADDR`, default 24'h000000: `addr` value driven during the key phase.
- `TEXT_ADDR`, default 24'h000020: `addr` value driven during the text phase.
- `RES_ADDR`, default 24'h000030: `addr` value driven during the hash and result phases.
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous reset, **active-high** (name kept for codebase consistency; asserted = 1).
- `start`  in  1  one-cycle request to run a transaction; sampled only in IDLE.
- `load_key`  in  1  sampled with `start`. 1 = run the key phase; 0 = skip it because the wrapper already holds a key.
- `encdec_in`  in  1  sampled with `start`; driven on `encdec` for the whole run.
- `key_in`  in  256  key; sampled with `start`; sent MSB byte first.
- `text_in`  in  128  plaintext; sampled with `start`; sent MSB byte first.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run completes successfully.
- `error`  out  1  one-cycle pulse on timeout abort.
- `result`  out  128  ciphertext; first received byte goes to [127:120]; holds its value until the next run's first byte.
- `aes_data_in`  out  8  byte to the wrapper's `data_in`.
- `aes_valid_in`  out  1  to the wrapper's `valid_in`.
- `aes_ready_in`  in  1  from the wrapper's `ready_in`.
- `aes_data_out`  in  8  from the wrapper's `data_out`.
- `aes_data_valid`  in  1  from the wrapper's `data_valid`.
- `aes_data_ready`  out  1  to the wrapper's `data_ready`.
- `aes_ack_valid`  in  1  from the wrapper's `ack_valid`.
- `aes_ack_ready`  out  1  to the wrapper's `ack_ready`.
- `aes_module_source_id`  in  2  from the wrapper's `module_source_id`.
- `opcode`, `source_id`, `dest_id`  out  2 each  transaction bus.
- `encdec`  out  1  transaction bus.
- `addr`  out  24  transaction bus.

## Operation
- Encodings:
  - Opcodes: LOAD_KEY=00, LOAD_TEXT=01, WRITE_RESULT=10 (never issued), HASH=11.
  - IDs: MEM=00, AES=10.
  - Bus idle value: opcode=00, source_id=00, dest_id=00, addr=0. `dest_id` is not AES, so the wrapper ignores it.
- States: IDLE, KEY, TEXT, HASH, RX, ACK, ERR.
- IDLE: on `start`, latch the inputs and clear the 6-bit `cnt` and the timeout counter.
  - If `load_key`=1, go to KEY; otherwise go to TEXT.
- KEY:
  - Drive opcode LOAD_KEY, source MEM, dest AES, `addr`=KEY_ADDR.
  - Drive `aes_valid_in`=1 with `aes_data_in` = key[255-8*cnt -: 8].
  - A beat transfers when `aes_valid_in && aes_ready_in`; then `cnt`++.
  - The beat with `cnt`=31 transfers → TEXT with `cnt`=0.
- TEXT: same as KEY, with opcode LOAD_TEXT, `addr`=TEXT_ADDR, 16 beats from `text_in`. The beat with `cnt`=15 → HASH with `cnt`=0.
- HASH:
  - Drive opcode HASH, source MEM, dest AES, `addr`=RES_ADDR; `aes_valid_in`=0; `aes_data_ready`=1.
  - The first `aes_data_valid` captures a byte, increments `cnt`, and moves to RX.
- RX:
  - Bus at idle value with `addr`=RES_ADDR; `aes_data_ready`=1.
  - Each cycle with `aes_data_valid`: result[127-8*cnt -: 8] ← `aes_data_out`, `cnt`++.
  - The 16th byte → ACK.
- ACK:
  - `aes_ack_ready`=1 (combinational from state).
  - On `aes_ack_valid && aes_module_source_id==2'b10`: pulse `done`, go to IDLE.
  - An ack with any other source ID is ignored.
- Timeout:
  - The counter clears on every state change and every byte transfer, and increments otherwise in non-IDLE states.
  - When it reaches `TIMEOUT`-1 → ERR.
  - ERR lasts one cycle: pulse `error`, bus idle, all handshake outputs 0, then IDLE.
  - `result` keeps the partially written contents.
- `start` while `busy` is ignored; no queueing.
- `aes_data_valid` outside HASH/RX is ignored.

## Timing
- Reset (`rst_n`=1, takes effect immediately, mid-run included):
  - state IDLE; `cnt`=0; `result`=0.
  - All outputs 0: bus at idle value, `aes_valid_in`, `aes_data_ready`, `aes_ack_ready`, `busy`, `done`, `error`.
- All outputs are registered except `aes_ack_ready` and `busy`, which decode the state register.
- `start` at edge N → `busy`=1 and KEY/TEXT command driven after edge N.
- Beats: with `aes_ready_in` held at 1, one beat transfers per cycle.
- `aes_data_in`/`aes_valid_in` stay stable while `aes_ready_in`=0.
- Minimum run with `load_key`=1: 1 (start) + 32 + 16 cycles, plus core latency, plus 16 RX cycles, plus 1 ACK cycle.
- `done` is asserted in the cycle after the ack handshake; `result` is valid in that same cycle.
- Simultaneous last RX byte and `aes_ack_valid`: the byte is captured and the ack is not taken until the ACK state (at least 1 cycle later).

## Test plan
- **FIPS-197 AES-256 vector:** `load_key`=1, key 000102…1f, text 00112233445566778899aabbccddeeff, `encdec_in`=1. Required: `result`=8ea2b7ca516745bfeafc49904b496089, one `done` pulse, `busy` low afterwards.
- **Backpressure:** `aes_ready_in` low on every other cycle during KEY/TEXT. Required: same `result`, no duplicated or dropped byte, `aes_data_in` stable while stalled.
- **Key reuse:** second run with `load_key`=0 and new text 00…00. Required: no LOAD_KEY opcode issued; `result` = AES-256 of zero text under the loaded key (per golden model).
- **Timeout:** `TIMEOUT`=64, `aes_ready_in` stuck at 0. Required: ERR is reached 64 cycles after KEY entry, `error` pulses once, the bus returns to idle, and a later `start` is accepted.
- **Reset mid-KEY:** assert `rst_n` after 10 key beats. Required: all outputs 0 immediately and `result`=0; a subsequent full run, with the `aes` block also reset, passes the FIPS-197 vector.
- **Busy `start` / wrong-source ack:** pulse `start` during RX, and drive `aes_module_source_id`=01 with `aes_ack_valid`. Required: no restart and no `done` until the ack arrives with source ID 10.
